data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pkg.sv | 14 +
 rtl/data_mem_pipe_if.sv | 58 +++++
 rtl/data_mem_array.sv | 33 +++
 rtl/data_mem_pipe.sv | 146 ++++++++++++++
 tb/tb_data_mem_pipe.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared definitions for the data_mem_pipe slice: controller state enumeration
// and the default word width / depth used by the interface and the modules.
package data_mem_pkg;

  localparam int unsigned DefaultDw    = 8;
  localparam int unsigned DefaultDepth = 256;

  // StInit: post-reset clear sweep; StRun: normal read/write service.
  typedef enum logic [0:0] {
    StInit,
    StRun
  } state_e;

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bundle for data_mem_pipe.
//   master: drives wr_en/w_add/ip/rd_en/r_add, receives op/op_valid/busy.
//   slave : the memory side (data_mem_pipe).
// With DATA_MEM_PARITY_EN defined the bundle also carries inj_err (request side)
// and par_err (response side).
interface data_mem_pipe_if
  import data_mem_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned DEPTH = DefaultDepth
) ();

  localparam int unsigned AW = $clog2(DEPTH);

  logic          wr_en;
  logic [AW-1:0] w_add;
  logic [DW-1:0] ip;
  logic          rd_en;
  logic [AW-1:0] r_add;
  logic [DW-1:0] op;
  logic          op_valid;
  logic          busy;
`ifdef DATA_MEM_PARITY_EN
  logic          inj_err;
  logic          par_err;
`endif

  modport master (
    output wr_en,
    output w_add,
    output ip,
    output rd_en,
    output r_add,
`ifdef DATA_MEM_PARITY_EN
    output inj_err,
    input  par_err,
`endif
    input  op,
    input  op_valid,
    input  busy
  );

  modport slave (
    input  wr_en,
    input  w_add,
    input  ip,
    input  rd_en,
    input  r_add,
`ifdef DATA_MEM_PARITY_EN
    input  inj_err,
    output par_err,
`endif
    output op,
    output op_valid,
    output busy
  );

endinterface

// File: rtl/data_mem_array.sv
// Storage array for data_mem_pipe: one write port, one synchronous read port,
// no reset (contents are cleared only by the controller's sweep).
//   clk_i    : clock
//   we_i     : write enable, waddr_i / wdata_i written on the rising edge
//   re_i     : read enable, rdata_o loads mem[raddr_i] on the rising edge
//   rdata_o  : registered read word, holds while re_i is low
// Addresses presented with an enable must be below DEPTH.
module data_mem_array #(
  parameter int unsigned WW    = 8,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [WW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [WW-1:0] rdata_o
);

  logic [WW-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Word memory with a post-reset clear sweep, latency-1 reads, write-first
// bypass and address range checking.
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : data_mem_pipe_if.slave (wr_en, w_add, ip, rd_en, r_add -> op, op_valid, busy)
// Optional build macro DATA_MEM_PARITY_EN adds an even-parity bit per stored
// word plus bus.inj_err (store inverted parity) and bus.par_err (read mismatch).
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int unsigned DW    = DefaultDw,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic             clk,
  input logic             reset,
  data_mem_pipe_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef DATA_MEM_PARITY_EN
  localparam int unsigned PW = 1;
`else
  localparam int unsigned PW = 0;
`endif
  localparam int unsigned WW = DW + PW;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  logic          run;
  logic          w_in_range, r_in_range;
  logic          wr_acc, rd_acc, bypass;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_waddr;
  logic [WW-1:0] mem_wdata, wdata_run, mem_rdata;

  logic          valid_q;
  logic          zero_q;   // op forced to 0: after reset or out-of-range read
  logic          byp_q;    // op taken from byp_data_q instead of the array
  logic [DW-1:0] byp_data_q;

  // Controller: sweep pointer walks 0..DEPTH-1, then hand over to RUN.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
          ptr_d   = '0;
        end
      end
      StRun: ;
      default: begin
        state_d = StInit;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Request qualification. DEPTH need not be a power of two, so some
  // encodable addresses are outside the array.
  always_comb begin
    run        = (state_q == StRun);
    w_in_range = (32'(bus.w_add) < DEPTH);
    r_in_range = (32'(bus.r_add) < DEPTH);
    wr_acc     = run & bus.wr_en & w_in_range;
    rd_acc     = run & bus.rd_en;
    bypass     = rd_acc & wr_acc & (bus.w_add == bus.r_add);
    mem_re     = rd_acc & r_in_range & ~bypass;
  end

`ifdef DATA_MEM_PARITY_EN
  assign wdata_run = {(^bus.ip) ^ bus.inj_err, bus.ip};
`else
  assign wdata_run = bus.ip;
`endif

  // Sweep owns the write port in INIT; reset gating keeps the array untouched
  // while reset is held.
  always_comb begin
    mem_we    = (~run & ~reset) | wr_acc;
    mem_waddr = run ? bus.w_add : ptr_q;
    mem_wdata = run ? wdata_run : '0;
  end

  data_mem_array #(
    .WW    (WW),
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (mem_re),
    .raddr_i (bus.r_add),
    .rdata_o (mem_rdata)
  );

  // Output source selection is registered alongside the array read, so op is
  // a function of registers only and holds whenever no read is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      zero_q     <= 1'b1;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
    end else begin
      valid_q <= rd_acc;
      if (rd_acc) begin
        zero_q <= ~r_in_range;
        byp_q  <= bypass;
      end
      if (bypass) begin
        byp_data_q <= bus.ip;
      end
    end
  end

  always_comb begin
    bus.busy     = ~run;
    bus.op_valid = valid_q;
    if (zero_q) begin
      bus.op = '0;
    end else if (byp_q) begin
      bus.op = byp_data_q;
    end else begin
      bus.op = mem_rdata[DW-1:0];
    end
`ifdef DATA_MEM_PARITY_EN
    bus.par_err = valid_q & ~zero_q & ~byp_q & (^mem_rdata);
`endif
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe (DW=8, DEPTH=12).
module tb_data_mem_pipe;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 12;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  data_mem_pipe_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  data_mem_pipe #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; a read pushes its hand-computed expectation.
  task automatic cyc(input logic w, input int wa, input logic [DW-1:0] d, input logic r,
                     input int ra, input logic inj, input logic [DW-1:0] exp_d,
                     input logic exp_p);
    exp_t e;
    bus.wr_en = w;
    bus.w_add = AW'(wa);
    bus.ip    = d;
    bus.rd_en = r;
    bus.r_add = AW'(ra);
`ifdef DATA_MEM_PARITY_EN
    bus.inj_err = inj;
`endif
    if (r) begin
      e.data = exp_d;
      e.par  = exp_p;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic wait_sweep();
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 100) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("busy cycles", busy_cnt, DEPTH);
  endtask

  // Monitor: every op_valid consumes one expectation.
  always @(negedge clk) begin
    if (!reset && bus.op_valid) begin
      if (sb.size() == 0) begin
        check("unexpected op_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("read data", 32'(bus.op), 32'(mon_e.data));
`ifdef DATA_MEM_PARITY_EN
        check("par_err", 32'(bus.par_err), 32'(mon_e.par));
`endif
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.w_add = '0;
    bus.ip    = '0;
    bus.rd_en = 1'b0;
    bus.r_add = '0;
`ifdef DATA_MEM_PARITY_EN
    bus.inj_err = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset op", 32'(bus.op), 32'h0);
    check("reset op_valid", 32'(bus.op_valid), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h1);

    // Release; requests held during the sweep must be ignored.
    reset     = 1'b0;
    bus.wr_en = 1'b1;
    bus.w_add = AW'(3);
    bus.ip    = 8'h55;
    bus.rd_en = 1'b1;
    bus.r_add = AW'(3);
    wait_sweep();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;

    for (int a = 0; a < int'(DEPTH); a++) begin
      cyc(1'b0, 0, 8'h00, 1'b1, a, 1'b0, 8'h00, 1'b0);
    end

    // Basic write then back-to-back reads.
    cyc(1'b1, 1, 8'hF8, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 2, 8'hF9, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 3, 8'hFA, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 1, 1'b0, 8'hF8, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 2, 1'b0, 8'hF9, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 3, 1'b0, 8'hFA, 1'b0);
    idle();
    check("hold op", 32'(bus.op), 32'hFA);
    check("hold op_valid", 32'(bus.op_valid), 32'h0);

    // Write-first bypass, then simultaneous access to different addresses.
    cyc(1'b1, 5, 8'hA5, 1'b1, 5, 1'b0, 8'hA5, 1'b0);
    cyc(1'b1, 6, 8'h11, 1'b1, 1, 1'b0, 8'hF8, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 6, 1'b0, 8'h11, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 5, 1'b0, 8'hA5, 1'b0);

    // Range: last valid address works, out-of-range write dropped, read gives 0.
    cyc(1'b1, 11, 8'hBB, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 13, 8'h77, 1'b1, 13, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 11, 1'b0, 8'hBB, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 13, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 15, 1'b0, 8'h00, 1'b0);

    // Mid-operation reset.
    cyc(1'b1, 4, 8'h3C, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 4, 1'b0, 8'h3C, 1'b0);
    idle();
    #2 reset = 1'b1;
    #1;
    check("mid reset op", 32'(bus.op), 32'h0);
    check("mid reset busy", 32'(bus.busy), 32'h1);
    check("mid reset op_valid", 32'(bus.op_valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_sweep();
    cyc(1'b0, 0, 8'h00, 1'b1, 4, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 5, 1'b0, 8'h00, 1'b0);

`ifdef DATA_MEM_PARITY_EN
    cyc(1'b1, 7, 8'h01, 1'b0, 0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 7, 1'b0, 8'h01, 1'b1);
    cyc(1'b1, 7, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 7, 1'b0, 8'h01, 1'b0);
    cyc(1'b1, 7, 8'h03, 1'b1, 7, 1'b1, 8'h03, 1'b0);
    cyc(1'b0, 0, 8'h00, 1'b1, 13, 1'b0, 8'h00, 1'b0);
`endif

    repeat (3) idle();
    check("scoreboard drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
